dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port word-addressed data memory (synchronous write, combinational read, 64 KiB, word index = address[15:2]). It shares the memory between the CPU load/store port (port 0) and the DMA/program-loader port (port 1) using a req/ack handshake. Grants alternate round-robin, each access is issued as one registered memory cycle, and read data is captured into per-port registers. Misaligned and out-of-range addresses are rejected with an error response and never reach the memory.

---
 rtl/dmem_pkg.sv | 7 +
 rtl/dmem_arbiter_if.sv | 23 ++
 rtl/rr_arb2.sv | 19 +
 rtl/dmem_arbiter.sv | 71 +++++++
 tb/tb_dmem_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state type, port indices and default memory size for dmem_arbiter
package dmem_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;
   localparam int MEM_BYTES_DEF = 65536;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: two requester ports plus the single-port memory bus
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              p0_req, p0_we, p0_ack, p0_err;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_wdata, p0_rdata;
   logic              p1_req, p1_we, p1_ack, p1_err;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_wdata, p1_rdata;
   logic              mem_read, mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, mem_rdata,
      output p0_ack, p0_err, p0_rdata, p1_ack, p1_err, p1_rdata, mem_read, mem_write, mem_addr, mem_wdata
   );
   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, mem_rdata,
      input  p0_ack, p0_err, p0_rdata, p1_ack, p1_err, p1_rdata, mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-request round-robin picker; mask removes requesters from contention
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic [1:0] mask,
   input  logic       take,
   output logic       valid,
   output logic       idx
);
   logic       last;
   logic [1:0] r;
   assign r     = req & ~mask;
   assign valid = |r;
   assign idx   = &r ? ~last : r[1];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) last <= 1'b1;
      else if (take && valid) last <= idx;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of a single-port data memory between CPU and DMA ports
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_BYTES = MEM_BYTES_DEF
) (
   input logic           clk,
   input logic           rst_n,
   dmem_arbiter_if.slave bus
);
   state_t            state, nxt;
   logic              owner, we_r, err_r;
   logic              take, valid, idx, load;
   logic [1:0]        mask;
   logic              sel_we, sel_err;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              fin0, fin1;
   // in RESP the port just served is masked out so the other one gets the next slot
   assign mask = state == RESP ? (owner == PORT_DMA ? 2'b10 : 2'b01) : 2'b00;
   assign take = state != ACCESS;
   assign load = take && valid;
   rr_arb2 u_arb (
      .clk, .rst_n, .req({bus.p1_req, bus.p0_req}), .mask, .take, .valid, .idx
   );
   assign sel_we    = idx == PORT_DMA ? bus.p1_we    : bus.p0_we;
   assign sel_addr  = idx == PORT_DMA ? bus.p1_addr  : bus.p0_addr;
   assign sel_wdata = idx == PORT_DMA ? bus.p1_wdata : bus.p0_wdata;
   assign sel_err   = |sel_addr[1:0] || sel_addr >= ADDR_W'(MEM_BYTES);
   assign fin0      = state == ACCESS && owner == PORT_CPU;
   assign fin1      = state == ACCESS && owner == PORT_DMA;
   always_comb nxt = state == ACCESS ? RESP : load ? ACCESS : IDLE;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= nxt;
   // mem_* are loaded on the edge entering ACCESS and cleared on the edge leaving it
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         owner         <= PORT_DMA;
         we_r          <= 1'b0;
         err_r         <= 1'b0;
         bus.mem_read  <= 1'b0;
         bus.mem_write <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.p0_ack    <= 1'b0;
         bus.p0_err    <= 1'b0;
         bus.p0_rdata  <= '0;
         bus.p1_ack    <= 1'b0;
         bus.p1_err    <= 1'b0;
         bus.p1_rdata  <= '0;
      end else begin
         bus.mem_read  <= load && !sel_err && !sel_we;
         bus.mem_write <= load && !sel_err && sel_we;
         bus.mem_addr  <= load && !sel_err ? sel_addr : '0;
         bus.mem_wdata <= load && !sel_err ? sel_wdata : '0;
         bus.p0_ack    <= fin0;
         bus.p0_err    <= fin0 && err_r;
         bus.p1_ack    <= fin1;
         bus.p1_err    <= fin1 && err_r;
         if (load) begin
            owner <= idx;
            we_r  <= sel_we;
            err_r <= sel_err;
         end
         if (fin0 && (err_r || !we_r)) bus.p0_rdata <= err_r ? '0 : bus.mem_rdata;
         if (fin1 && (err_r || !we_r)) bus.p1_rdata <= err_r ? '0 : bus.mem_rdata;
      end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors and multi-cycle sequences for dmem_arbiter
module tb_dmem_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   always #5 clk = ~clk;
   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   dmem_arbiter u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   logic [31:0] mem [0:16383];
   always_ff @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[15:2]] <= bus.mem_wdata;
   assign bus.mem_rdata = mem[bus.mem_addr[15:2]];
   typedef struct {
      logic        p;
      logic        we;
      logic [31:0] a;
      logic [31:0] d;
      logic        e;
      logic [31:0] rd;
   } vec_t;
   vec_t vecs [11];
   task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask
   task automatic set_port(input logic p, input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
      if (!p) begin
         bus.p0_req = r; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
      end else begin
         bus.p1_req = r; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
      end
   endtask
   task automatic chk_reset(input string n);
      check({n, "_flags"}, 32'({bus.p0_ack, bus.p0_err, bus.p1_ack, bus.p1_err, bus.mem_read, bus.mem_write}), 0);
      check({n, "_rdata0"}, bus.p0_rdata, 0);
      check({n, "_rdata1"}, bus.p1_rdata, 0);
      check({n, "_maddr"}, bus.mem_addr, 0);
      check({n, "_mwdata"}, bus.mem_wdata, 0);
   endtask
   task automatic xact(input logic p, input logic we, input logic [31:0] a, input logic [31:0] d,
                       output logic e, output logic [31:0] rd, output int lat, output int act);
      lat = 0;
      act = 0;
      e   = 1'bx;
      rd  = 'x;
      set_port(p, 1'b1, we, a, d);
      for (int c = 1; c <= 10 && lat == 0; c++) begin
         @(posedge clk);
         #1;
         if (bus.mem_read || bus.mem_write)
            act += (bus.mem_addr == a && bus.mem_write == we && bus.mem_read == !we && (!we || bus.mem_wdata == d)) ? 1 : 100;
         if (p ? bus.p1_ack : bus.p0_ack) begin
            lat = c;
            e   = p ? bus.p1_err : bus.p0_err;
            rd  = p ? bus.p1_rdata : bus.p0_rdata;
         end
      end
      set_port(p, 1'b0, 1'b0, 0, 0);
      @(posedge clk);
      #1;
   endtask
   task automatic tie(output int a0, output int a1);
      a0 = 0;
      a1 = 0;
      set_port(0, 1'b1, 1'b0, 32'h10, 0);
      set_port(1, 1'b1, 1'b0, 32'h20, 0);
      for (int c = 1; c <= 20 && (a0 == 0 || a1 == 0); c++) begin
         @(posedge clk);
         #1;
         if (bus.p0_ack && bus.p1_ack) check("tie_double_ack", 1, 0);
         if (bus.p0_ack && a0 == 0) begin
            a0 = c;
            check("tie_rdata0", bus.p0_rdata, 32'hDEADBEEF);
            set_port(0, 1'b0, 1'b0, 0, 0);
         end
         if (bus.p1_ack && a1 == 0) begin
            a1 = c;
            check("tie_rdata1", bus.p1_rdata, 32'hCAFE0001);
            set_port(1, 1'b0, 1'b0, 0, 0);
         end
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      logic        e;
      logic [31:0] rd;
      int          lat, act, a0, a1, n, lastp, seen;
      int          last_ack [2];
      vecs[0]  = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0};
      vecs[1]  = '{1'b0, 1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
      vecs[2]  = '{1'b1, 1'b1, 32'h20,       32'hCAFE0001, 1'b0, 32'h0};
      vecs[3]  = '{1'b1, 1'b0, 32'h20,       32'h0,        1'b0, 32'hCAFE0001};
      vecs[4]  = '{1'b1, 1'b0, 32'h3,        32'h0,        1'b1, 32'h0};
      vecs[5]  = '{1'b1, 1'b1, 32'hFFFC,     32'h55AA55AA, 1'b0, 32'h0};
      vecs[6]  = '{1'b0, 1'b0, 32'hFFFC,     32'h0,        1'b0, 32'h55AA55AA};
      vecs[7]  = '{1'b1, 1'b0, 32'h10000,    32'h0,        1'b1, 32'h0};
      vecs[8]  = '{1'b0, 1'b1, 32'h2,        32'h1234,     1'b1, 32'h0};
      vecs[9]  = '{1'b0, 1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
      vecs[10] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0};
      set_port(0, 1'b0, 1'b0, 0, 0);
      set_port(1, 1'b0, 1'b0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk_reset("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      foreach (vecs[i]) begin
         xact(vecs[i].p, vecs[i].we, vecs[i].a, vecs[i].d, e, rd, lat, act);
         check($sformatf("v%0d_latency", i), 32'(lat), 2);
         check($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].e));
         check($sformatf("v%0d_rdata", i), rd, vecs[i].rd);
         check($sformatf("v%0d_mem_cycles", i), 32'(act), vecs[i].e ? 0 : 1);
      end
      // fresh reset: last pointer favours port 0 on the first tie
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tie(a0, a1);
      check("tie1_p0_ack", 32'(a0), 2);
      check("tie1_p1_ack", 32'(a1), 4);
      tie(a0, a1);
      check("tie2_p0_ack", 32'(a0), 2);
      check("tie2_p1_ack", 32'(a1), 4);
      xact(1'b0, 1'b0, 32'h10, 0, e, rd, lat, act);
      tie(a0, a1);
      check("tie3_p1_ack", 32'(a1), 2);
      check("tie3_p0_ack", 32'(a0), 4);
      // continuous contention: acks must alternate
      n = 0;
      lastp = -1;
      last_ack[0] = 0;
      last_ack[1] = 0;
      set_port(0, 1'b1, 1'b0, 32'h10, 0);
      set_port(1, 1'b1, 1'b0, 32'h20, 0);
      for (int c = 1; c <= 80 && n < 20; c++) begin
         @(posedge clk);
         #1;
         if (bus.p0_ack && bus.p1_ack) check("cont_double_ack", 1, 0);
         for (int p = 0; p < 2; p++) begin
            if (p == 0 ? bus.p0_ack : bus.p1_ack) begin
               n++;
               if (lastp >= 0) check("cont_alternate", 32'(p), 32'(1 - lastp));
               if (last_ack[p] != 0) check("cont_gap_le4", 32'(c - last_ack[p] <= 4), 1);
               last_ack[p] = c;
               lastp = p;
            end
         end
      end
      check("cont_count", 32'(n), 20);
      set_port(0, 1'b0, 1'b0, 0, 0);
      set_port(1, 1'b0, 1'b0, 0, 0);
      repeat (4) @(posedge clk);
      #1;
      // reset in the middle of a write's ACCESS cycle
      set_port(0, 1'b1, 1'b1, 32'h20, 32'h12345678);
      @(posedge clk);
      #1;
      check("abort_mw_before", 32'(bus.mem_write), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_mw_drop", 32'(bus.mem_write), 0);
      set_port(0, 1'b0, 1'b0, 0, 0);
      chk_reset("held");
      @(posedge clk);
      #1;
      chk_reset("held2");
      rst_n = 1'b1;
      seen = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         seen |= 32'(bus.p0_ack);
      end
      check("abort_no_ack", 32'(seen), 0);
      xact(1'b0, 1'b0, 32'h20, 0, e, rd, lat, act);
      check("abort_old_value", rd, 32'hCAFE0001);
      check("abort_read_err", 32'(e), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
